// File: rtl/float_to_fixed_sp.sv
// IEEE-754 single to signed 32-bit fixed-point converter, round-to-nearest-even,
// saturating, with a single global advance enable shared by every pipeline stage.
module float_to_fixed_sp #(
  parameter int unsigned p_FRAC_BITS = 0
) (
  input  logic        i_CLK,
  input  logic        i_RST_N,
  input  logic [31:0] i_FLOAT_WORD,
  input  logic        i_VALID,
  output logic        o_READY,
  output logic [31:0] o_FIXED_WORD,
  output logic        o_VALID,
  input  logic        i_READY,
  output logic        o_OVERFLOW,
  output logic        o_INVALID,
  output logic        o_INEXACT
);

  typedef enum logic [1:0] {
    CLS_NORM,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } cls_e;

  logic w_en;

  logic r_s1_valid;
  logic r_s2_valid;
  logic r_s3_valid;
  logic r_out_valid;

  logic [31:0] r_out_word;
  logic        r_out_ovf;
  logic        r_out_inv;
  logic        r_out_inx;

  // The whole pipe advances together; a stalled output freezes every stage.
  assign w_en    = ~r_out_valid | i_READY;
  assign o_READY = w_en;

  // ---------------------------------------------------------------------------
  // Stage 1: field split, exponent rebias and classification
  // ---------------------------------------------------------------------------
  logic              w_in_sign;
  logic [7:0]        w_in_exp;
  logic [22:0]       w_in_frac;
  logic signed [9:0] w_in_k;
  cls_e              w_in_cls;

  assign w_in_sign = i_FLOAT_WORD[31];
  assign w_in_exp  = i_FLOAT_WORD[30:23];
  assign w_in_frac = i_FLOAT_WORD[22:0];
  assign w_in_k    = $signed({2'b00, w_in_exp}) - 10'sd127 + $signed(10'(p_FRAC_BITS));

  always_comb begin
    // NOTE: a default assignment first in every always_comb keeps each path
    // driving the signal, so no latch is inferred.
    w_in_cls = CLS_NORM;
    if (w_in_exp == 8'hFF) begin
      w_in_cls = (w_in_frac != '0) ? CLS_NAN : CLS_INF;
    end else if (w_in_exp == 8'h00) begin
      w_in_cls = CLS_ZERO;
    end
  end

  logic              r_s1_sign;
  logic [23:0]       r_s1_man;
  logic signed [9:0] r_s1_k;
  cls_e              r_s1_cls;

  // NOTE: datapath registers carry no reset; the stage-valid bits alone decide
  // whether their contents mean anything, which keeps the reset tree small.
  always_ff @(posedge i_CLK) begin
    if (w_en) begin
      r_s1_sign <= w_in_sign;
      r_s1_man  <= {1'b1, w_in_frac};
      r_s1_k    <= w_in_k;
      r_s1_cls  <= w_in_cls;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: align the 24-bit significand to the output binary point
  // ---------------------------------------------------------------------------
  logic [2:0]  w_lsh;
  logic [4:0]  w_rsh;
  logic [49:0] w_ext;
  logic [31:0] w_al_mag;
  logic        w_al_g;
  logic        w_al_st;
  logic        w_al_ovf;

  assign w_lsh = 3'(r_s1_k - 10'sd23);
  assign w_rsh = 5'(10'sd23 - r_s1_k);

  always_comb begin
    w_ext    = '0;
    w_al_mag = '0;
    w_al_g   = 1'b0;
    w_al_st  = 1'b0;
    w_al_ovf = 1'b0;
    if (r_s1_k >= 10'sd31) begin
      // Only -2^31 itself is representable at this weight.
      if (r_s1_sign && (r_s1_k == 10'sd31) && (r_s1_man[22:0] == '0)) begin
        w_al_mag = 32'h8000_0000;
      end else begin
        w_al_ovf = 1'b1;
      end
    end else if (r_s1_k >= 10'sd23) begin
      w_al_mag = {8'b0, r_s1_man} << w_lsh;
    end else if (r_s1_k >= -10'sd2) begin
      // Shift into a wide window so guard and sticky fall out of the low bits.
      w_ext    = {r_s1_man, 26'b0} >> w_rsh;
      w_al_mag = {8'b0, w_ext[49:26]};
      w_al_g   = w_ext[25];
      w_al_st  = |w_ext[24:0];
    end else begin
      w_al_st = 1'b1;
    end
  end

  logic        r_s2_sign;
  logic [31:0] r_s2_mag;
  logic        r_s2_g;
  logic        r_s2_st;
  logic        r_s2_ovf;
  logic        r_s2_frac_nz;
  cls_e        r_s2_cls;

  always_ff @(posedge i_CLK) begin
    if (w_en) begin
      r_s2_sign    <= r_s1_sign;
      r_s2_mag     <= w_al_mag;
      r_s2_g       <= w_al_g;
      r_s2_st      <= w_al_st;
      r_s2_ovf     <= w_al_ovf;
      r_s2_frac_nz <= |r_s1_man[22:0];
      r_s2_cls     <= r_s1_cls;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: round to nearest-even and resolve the flags
  // ---------------------------------------------------------------------------
  logic        w_round_up;
  logic [31:0] w_rnd_mag;
  logic [31:0] w_s3_mag;
  logic        w_s3_ovf;
  logic        w_s3_inv;
  logic        w_s3_inx;

  assign w_round_up = r_s2_g & (r_s2_st | r_s2_mag[0]);
  assign w_rnd_mag  = r_s2_mag + {31'b0, w_round_up};

  always_comb begin
    w_s3_mag = '0;
    w_s3_ovf = 1'b0;
    w_s3_inv = 1'b0;
    w_s3_inx = 1'b0;
    case (r_s2_cls)
      CLS_NAN:  w_s3_inv = 1'b1;
      CLS_INF:  w_s3_ovf = 1'b1;
      CLS_ZERO: w_s3_inx = r_s2_frac_nz;
      default: begin
        if (r_s2_ovf) begin
          w_s3_ovf = 1'b1;
        end else begin
          w_s3_mag = w_rnd_mag;
          w_s3_inx = r_s2_g | r_s2_st;
        end
      end
    endcase
  end

  logic        r_s3_sign;
  logic [31:0] r_s3_mag;
  logic        r_s3_ovf;
  logic        r_s3_inv;
  logic        r_s3_inx;

  always_ff @(posedge i_CLK) begin
    if (w_en) begin
      r_s3_sign <= r_s2_sign;
      r_s3_mag  <= w_s3_mag;
      r_s3_ovf  <= w_s3_ovf;
      r_s3_inv  <= w_s3_inv;
      r_s3_inx  <= w_s3_inx;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register: sign application and saturation
  // ---------------------------------------------------------------------------
  logic [31:0] w_out_word;

  always_comb begin
    w_out_word = r_s3_sign ? (~r_s3_mag + 32'd1) : r_s3_mag;
    if (r_s3_ovf) begin
      w_out_word = r_s3_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (!i_RST_N) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s3_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
      r_out_ovf   <= 1'b0;
      r_out_inv   <= 1'b0;
      r_out_inx   <= 1'b0;
    end else if (w_en) begin
      r_s1_valid  <= i_VALID;
      r_s2_valid  <= r_s1_valid;
      r_s3_valid  <= r_s2_valid;
      r_out_valid <= r_s3_valid;
      r_out_word  <= w_out_word;
      r_out_ovf   <= r_s3_ovf;
      r_out_inv   <= r_s3_inv;
      r_out_inx   <= r_s3_inx;
    end
  end

  assign o_VALID      = r_out_valid;
  assign o_FIXED_WORD = r_out_word;
  assign o_OVERFLOW   = r_out_ovf;
  assign o_INVALID    = r_out_inv;
  assign o_INEXACT    = r_out_inx;

endmodule
